// File: rtl/uart_mmio_pkg.sv
// Register map and field positions shared by the UART MMIO bridge and its RX FIFO.
// No logic here; latency and backpressure are defined by the modules that import it.
// Holds the default RX FIFO depth.
package uart_mmio_pkg;

  localparam int RX_DEPTH_DEFAULT = 4;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int STATUS_RX_AVAIL = 0;
  localparam int STATUS_TX_SPACE = 1;
  localparam int STATUS_TX_DROP  = 2;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

  // Field order matches the STATUS_* / CTRL_* bit positions above (LSB last).
  typedef struct packed {
    logic tx_drop;
    logic tx_space;
    logic rx_avail;
  } status_t;

  typedef struct packed {
    logic tx_ie;
    logic rx_ie;
  } ctrl_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received UART data; DEPTH must be a power of two, at least 2.
// Latency: push visible at head on the next cycle; head is combinational from storage.
// Backpressure: push is ignored when full and pop when empty; full/empty are registered-state only.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_dat,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_bridge.sv
// MMIO register front-end for a byte-stream UART: RX FIFO, one-entry TX holding register, STATUS/CTRL; irq and CTRL exist only with UART_MMIO_IRQ_EN.
// Latency: rd_data registered, valid the cycle after rd_en; tx_valid rises the cycle after a DATA write.
// Backpressure: rx_ready drops when the RX FIFO is full; TX writes to a busy holding register are dropped and flagged.
module uart_mmio_bridge
  import uart_mmio_pkg::*;
#(
  parameter int RX_DEPTH = RX_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data
`ifdef UART_MMIO_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_head;
  logic        rx_push;
  logic        fifo_pop;
  logic        tx_full;
  logic        tx_drop;
  logic        tx_load;
  logic        tx_drop_evt;
  logic        wr_data_hit;
  logic        wr_stat_hit;
  logic [31:0] rd_mux;
  status_t     status;
  logic        unused_wr_hi;

  assign unused_wr_hi = ^wr_data[31:8];

  assign rx_ready = ~fifo_full;
  assign rx_push  = rx_valid & ~fifo_full;
  assign fifo_pop = rd_en & (addr == REG_DATA) & ~fifo_empty;

  uart_rx_fifo #(
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rx_push),
    .push_dat (rx_data),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  // A full holding register can still take a byte if it is being drained this cycle.
  assign wr_data_hit = wr_en & (addr == REG_DATA);
  assign wr_stat_hit = wr_en & (addr == REG_STATUS);
  assign tx_load     = wr_data_hit & (~tx_full | tx_ready);
  assign tx_drop_evt = wr_data_hit & ~tx_load;
  assign tx_valid    = tx_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_full <= 1'b0;
      tx_data <= '0;
      tx_drop <= 1'b0;
    end else begin
      if (tx_load) begin
        tx_full <= 1'b1;
        tx_data <= wr_data[7:0];
      end else if (tx_ready) begin
        tx_full <= 1'b0;
      end
      if (tx_drop_evt)      tx_drop <= 1'b1;
      else if (wr_stat_hit) tx_drop <= 1'b0;
    end
  end

  assign status = '{tx_drop: tx_drop, tx_space: ~tx_full, rx_avail: ~fifo_empty};

`ifdef UART_MMIO_IRQ_EN
  ctrl_t ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr_en && addr == REG_CTRL) ctrl <= ctrl_t'(wr_data[1:0]);
      irq <= (ctrl.rx_ie & status.rx_avail) | (ctrl.tx_ie & status.tx_space);
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_DATA:   if (!fifo_empty) rd_mux = {24'h0, fifo_head};
      REG_STATUS: rd_mux = {29'h0, status};
`ifdef UART_MMIO_IRQ_EN
      REG_CTRL:   rd_mux = {30'h0, ctrl};
`else
      REG_CTRL:   rd_mux = '0;
`endif
      default:    rd_mux = '0;
    endcase
  end

  // Reads sample pre-write state, so a same-cycle write is not visible here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Randomised and directed stimulus for uart_mmio_bridge against a queue-based reference model.
// A negedge monitor pops expected reads, per-cycle flags and TX bytes from scoreboards.
module tb_uart_mmio_bridge;
  import uart_mmio_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        irq;

  always #5 clk = ~clk;

  uart_mmio_bridge #(
    .RX_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_data  (rx_data)
`ifdef UART_MMIO_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

`ifndef UART_MMIO_IRQ_EN
  assign irq = 1'b0;
`endif

  typedef struct packed {
    logic rx_rdy;
    logic tx_vld;
    logic irq;
  } cyc_t;

  cyc_t        cyc_q[$];
  logic [31:0] rd_q[$];
  logic [7:0]  tx_q[$];

  // Reference model state: the RX FIFO is just a byte queue.
  logic [7:0]  m_rx[$];
  logic        m_tx_full;
  logic        m_drop;
  logic [1:0]  m_ctrl;
  logic        m_irq;

  int n_vec = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  bit rd_prev = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void missing(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: DUT output with no expected entry at %0t", name, $time);
  endfunction

  always @(negedge clk) begin
    cyc_t c;
    if (!mon_en) begin
      rd_prev = 1'b0;
    end else begin
      if (rd_prev) begin
        if (rd_q.size() == 0) missing("rd_data");
        else check("rd_data", rd_data, rd_q.pop_front());
      end
      rd_prev = rd_en;
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        check("rx_ready", {31'h0, rx_ready}, {31'h0, c.rx_rdy});
        check("tx_valid", {31'h0, tx_valid}, {31'h0, c.tx_vld});
`ifdef UART_MMIO_IRQ_EN
        check("irq", {31'h0, irq}, {31'h0, c.irq});
`endif
      end
      if (tx_valid) begin
        if (tx_q.size() == 0) missing("tx_data");
        else begin
          check("tx_data", {24'h0, tx_data}, {24'h0, tx_q[0]});
          if (tx_ready) void'(tx_q.pop_front());
        end
      end
    end
  end

  // One bus/stream cycle: drive inputs just after the edge, then advance the model past the next edge.
  task automatic step(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] wd,
                      input logic rxv, input logic [7:0] rxd, input logic txr, output logic rx_acc);
    cyc_t        c;
    logic [31:0] rv;
    logic        pop;
    logic        load;
    @(posedge clk);
    #1;
    rd_en = rd; wr_en = wr; addr = a; wr_data = wd;
    rx_valid = rxv; rx_data = rxd; tx_ready = txr;
    c.rx_rdy = (m_rx.size() < DEPTH);
    c.tx_vld = m_tx_full;
    c.irq    = m_irq;
    cyc_q.push_back(c);
    m_irq = (m_ctrl[0] && m_rx.size() > 0) || (m_ctrl[1] && !m_tx_full);
    rv = 32'h0;
    case (a)
      2'd0:    if (m_rx.size() > 0) rv = {24'h0, m_rx[0]};
      2'd1:    rv = {29'h0, m_drop, !m_tx_full, m_rx.size() > 0};
      2'd2:    rv = {30'h0, m_ctrl};
      default: rv = 32'h0;
    endcase
    if (rd) rd_q.push_back(rv);
    rx_acc = rxv && (m_rx.size() < DEPTH);
    pop    = rd && a == 2'd0 && m_rx.size() > 0;
    load   = wr && a == 2'd0 && (!m_tx_full || txr);
    if (pop) void'(m_rx.pop_front());
    if (rx_acc) m_rx.push_back(rxd);
    if (wr && a == 2'd0 && !load) m_drop = 1'b1;
    else if (wr && a == 2'd1)     m_drop = 1'b0;
    if (load) tx_q.push_back(wd[7:0]);
    m_tx_full = load || (m_tx_full && !txr);
`ifdef UART_MMIO_IRQ_EN
    if (wr && a == 2'd2) m_ctrl = wd[1:0];
`endif
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n, input logic txr);
    logic acc;
    for (int i = 0; i < n; i++) step(0, 0, 2'd0, 32'h0, 0, 8'h0, txr, acc);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset = 1'b1;
    rd_en = 0; wr_en = 0; addr = 0; wr_data = 0;
    rx_valid = 0; rx_data = 0; tx_ready = 0;
    m_rx.delete(); m_tx_full = 0; m_drop = 0; m_ctrl = 0; m_irq = 0;
    cyc_q.delete(); rd_q.delete(); tx_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    check("rst_irq", {31'h0, irq}, 32'h0);
  endtask

  initial begin
    logic acc;
    int   idx;
    do_reset();

    // Two RX bytes, read back in order, then STATUS.
    step(0, 0, REG_DATA, 0, 1, 8'h41, 1, acc);
    step(0, 0, REG_DATA, 0, 1, 8'h42, 1, acc);
    step(1, 0, REG_DATA, 0, 0, 8'h00, 1, acc);
    step(1, 0, REG_DATA, 0, 0, 8'h00, 1, acc);
    step(1, 0, REG_STATUS, 0, 0, 8'h00, 1, acc);

    // Six bytes offered continuously into a four-deep FIFO, drained mid-way.
    idx = 1;
    for (int k = 0; k < 16; k++) begin
      step(k >= 6 && k < 10, 0, REG_DATA, 0, idx <= 6, idx[7:0], 1, acc);
      if (acc) idx++;
    end
    for (int k = 0; k < 3; k++) step(1, 0, REG_DATA, 0, 0, 8'h00, 1, acc);

    // TX stalled: second write dropped, then cleared through STATUS.
    step(0, 1, REG_DATA, 32'h55, 0, 0, 0, acc);
    step(0, 1, REG_DATA, 32'hAA, 0, 0, 0, acc);
    step(1, 0, REG_STATUS, 0, 0, 0, 0, acc);
    step(0, 1, REG_STATUS, 0, 0, 0, 0, acc);
    step(1, 0, REG_STATUS, 0, 0, 0, 0, acc);
    idle(2, 1);

    // Back-to-back writes with a ready sink.
    step(0, 1, REG_DATA, 32'h10, 0, 0, 1, acc);
    step(0, 1, REG_DATA, 32'h11, 0, 0, 1, acc);
    step(1, 0, REG_STATUS, 0, 0, 0, 1, acc);
    idle(2, 1);

    // Empty read, then one entry with same-cycle push and pop.
    step(1, 0, REG_DATA, 0, 0, 0, 1, acc);
    step(0, 0, REG_DATA, 0, 1, 8'h77, 1, acc);
    step(1, 0, REG_DATA, 0, 1, 8'h88, 1, acc);
    step(1, 0, REG_STATUS, 0, 0, 0, 1, acc);
    step(1, 0, REG_DATA, 0, 0, 0, 1, acc);
    step(1, 0, REG_DATA, 0, 0, 0, 1, acc);
    step(1, 0, 2'd3, 0, 0, 0, 1, acc);
    step(1, 1, REG_CTRL, 32'h3, 0, 0, 1, acc);
    step(1, 0, REG_CTRL, 0, 0, 0, 1, acc);
    step(0, 1, REG_CTRL, 32'h0, 0, 0, 1, acc);

`ifdef UART_MMIO_IRQ_EN
    step(0, 1, REG_CTRL, 32'h1, 0, 0, 1, acc);
    step(0, 0, REG_DATA, 0, 1, 8'h5A, 1, acc);
    idle(2, 1);
    step(1, 0, REG_DATA, 0, 0, 0, 1, acc);
    idle(3, 1);
    step(0, 1, REG_CTRL, 32'h2, 0, 0, 0, acc);
    step(0, 1, REG_DATA, 32'h3C, 0, 0, 0, acc);
    idle(3, 1);
`endif

    // Randomised traffic in two flavours: RX-heavy then TX/bus-heavy.
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 800; k++) begin
        step(($urandom % 4) == 0,
             ($urandom % (ph == 0 ? 6 : 2)) == 0,
             2'($urandom % 4),
             $urandom,
             ($urandom % (ph == 0 ? 4 : 2)) != 0,
             8'($urandom),
             ($urandom % 3) != 0,
             acc);
      end
    end

    // Reset while a TX byte is stalled and RX holds data.
    step(0, 1, REG_DATA, 32'hE7, 1, 8'h99, 0, acc);
    step(0, 0, REG_DATA, 0, 1, 8'h9A, 0, acc);
    @(posedge clk);
    #2;
    do_reset();
    step(1, 0, REG_STATUS, 0, 0, 0, 1, acc);
    step(1, 0, REG_DATA, 0, 0, 0, 1, acc);
    for (int k = 0; k < 200; k++) begin
      step(($urandom % 3) == 0, ($urandom % 3) == 0, 2'($urandom % 4), $urandom,
           ($urandom % 2) == 0, 8'($urandom), ($urandom % 2) == 0, acc);
    end
    idle(3, 1);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_mmio_bridge.md
UART_MMIO_BRIDGE -- requirements
Module: uart_mmio_bridge

Interface
REQ-001 SHALL have parameter RX_DEPTH, default 4, RX FIFO entries; power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port addr  input  2  word-register select: 0 DATA, 1 STATUS, 2 CTRL.
REQ-005 SHALL have port rd_en  input  1  bus read strobe, one cycle per access.
REQ-006 SHALL have port wr_en  input  1  bus write strobe, one cycle per access.
REQ-007 SHALL have port wr_data  input  32  bus write data; only bits [7:0] used.
REQ-008 SHALL have port rd_data  output  32  registered bus read data.
REQ-009 SHALL have port tx_valid  output  1  byte offered to the UART transmit stream.
REQ-010 SHALL have port tx_ready  input  1  UART accepts the transmit byte.
REQ-011 SHALL have port tx_data  output  8  transmit byte.
REQ-012 SHALL have port rx_valid  input  1  UART offers a received byte.
REQ-013 SHALL have port rx_ready  output  1  bridge accepts the received byte.
REQ-014 SHALL have port rx_data  input  8  received byte.

Function
REQ-015 Stream transfer SHALL occur exactly on a cycle with valid and ready both high.
REQ-016 rx_ready SHALL equal "RX FIFO not full", combinationally from registered state only.
REQ-017 An RX transfer SHALL write rx_data into the FIFO tail; the occupancy counter is clog2(RX_DEPTH)+1 bits wide and the pointers wrap modulo RX_DEPTH.
REQ-018 rd_en to DATA with FIFO non-empty SHALL return the head byte zero-extended and pop it; with FIFO empty it SHALL return 0 without popping.
REQ-019 A same-cycle push and pop SHALL leave the occupancy unchanged, including when exactly one entry is held.
REQ-020 TX SHALL be a one-entry holding register; tx_valid equals its full flag, and tx_data equals its contents, held stable while tx_valid is high and tx_ready is low.
REQ-021 wr_en to DATA SHALL load the holding register when it is empty, or full with tx_ready high in the same cycle; otherwise the byte is dropped and sticky TX_DROP sets.
REQ-022 STATUS read SHALL return bit0 RX_AVAIL (FIFO non-empty), bit1 TX_SPACE (holding register empty), bit2 TX_DROP, and all other bits 0.
REQ-023 wr_en to STATUS SHALL clear TX_DROP; a same-cycle drop SHALL win and leave it set.
REQ-024 rd_data SHALL be valid on the cycle after rd_en and hold until the next rd_en; a read of address 3 returns 0.
REQ-025 rd_en and wr_en in the same cycle SHALL both take effect; the read returns pre-write state.

Reset
REQ-026 Reset SHALL empty the FIFO, clear the TX full flag and TX_DROP, and drive rd_data=0, tx_valid=0, tx_data=0, rx_ready=1 after deassertion.
REQ-027 Reset asserted mid-transfer SHALL discard any in-flight byte without a partial transfer.

Configuration
REQ-028 With macro UART_MMIO_IRQ_EN defined, the block SHALL add output irq (1 bit) and a CTRL register with bit0 RX_IE and bit1 TX_IE, both reset to 0; irq is registered, = (RX_IE&RX_AVAIL)|(TX_IE&TX_SPACE).
REQ-029 Without UART_MMIO_IRQ_EN, there SHALL be no irq port; CTRL writes are ignored and CTRL reads return 0.

Structure
REQ-030 Package uart_mmio_pkg SHALL hold the register offsets, STATUS/CTRL bit positions, and default RX_DEPTH.
REQ-031 The RX FIFO SHALL be a sub-module uart_rx_fifo (parameterised depth, push/pop/full/empty/head).

Verification
REQ-032 Scenario: push 0x41,0x42 via rx stream, then read DATA twice -> rd_data 0x41 then 0x42; STATUS then reads 0x2.
REQ-033 Scenario: hold rx_valid high with 6 bytes and no reads, RX_DEPTH=4 -> rx_ready low after 4 transfers; 4 DATA reads return bytes 1-4 in order, and then bytes 5-6 are accepted.
REQ-034 Scenario: tx_ready=0, write 0x55 then 0xAA -> tx_data stays 0x55; STATUS=0x4; STATUS write -> 0x0.
REQ-035 Scenario: tx_ready=1, write 0x10 and 0x11 on consecutive cycles -> both emitted, no TX_DROP.
REQ-036 Scenario: read DATA on an empty FIFO -> rd_data 0, occupancy unchanged; one entry plus same-cycle push and pop -> occupancy stays 1.
REQ-037 Scenario: with UART_MMIO_IRQ_EN, CTRL=0x1, push one byte -> irq high the next cycle; after the DATA read, irq is low within 2 cycles.
